// File: rtl/sbqm_pkg.sv
// Shared widths, limits and the sensor filter state encoding for the
// queue occupancy counter.
package sbqm_pkg;

  localparam int PCOUNT_W = 3;
  localparam int TCOUNT_W = 2;

  localparam logic [PCOUNT_W-1:0] PCOUNT_MAX = 3'd7;
  localparam logic [TCOUNT_W-1:0] TCOUNT_MIN = 2'd1;
  localparam logic [TCOUNT_W-1:0] TCOUNT_MAX = 2'd3;

  typedef enum logic [1:0] {
    LOW,
    RISE_CHK,
    HIGH,
    FALL_CHK
  } filt_state_e;

endpackage

// File: rtl/sensor_conditioner.sv
// Photocell conditioner: 2-flop synchroniser, debounce filter FSM and a
// single-cycle event pulse for each accepted beam break.
module sensor_conditioner
  import sbqm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DBC_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_i,
  output logic evt_o
);

  // The counter is cleared on entry to a CHK state and that entry cycle
  // already counts as one stable sample, so the last count is D-2.
  localparam bit               SINGLE   = (DEBOUNCE_CYCLES == 1);
  localparam logic [DBC_W-1:0] LAST_CNT = (DEBOUNCE_CYCLES >= 2) ?
                                          DBC_W'(DEBOUNCE_CYCLES - 2) : '0;

  logic             meta_q;
  logic             sync_q;
  filt_state_e      state_q;
  logic [DBC_W-1:0] cnt_q;
  logic             evt_q;

  // Bring the asynchronous photocell level into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= sensor_i;
      sync_q <= meta_q;
    end
  end

  // Debounce FSM; evt_q pulses once on the edge a rising level is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOW;
      cnt_q   <= '0;
      evt_q   <= 1'b0;
    end else begin
      evt_q <= 1'b0;
      case (state_q)
        LOW: begin
          if (sync_q) begin
            if (SINGLE) begin
              state_q <= HIGH;
              evt_q   <= 1'b1;
            end else begin
              state_q <= RISE_CHK;
              cnt_q   <= '0;
            end
          end
        end
        RISE_CHK: begin
          if (!sync_q) begin
            state_q <= LOW;
          end else if (cnt_q == LAST_CNT) begin
            state_q <= HIGH;
            evt_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + DBC_W'(1);
          end
        end
        HIGH: begin
          if (!sync_q) begin
            if (SINGLE) begin
              state_q <= LOW;
            end else begin
              state_q <= FALL_CHK;
              cnt_q   <= '0;
            end
          end
        end
        FALL_CHK: begin
          if (sync_q) begin
            state_q <= HIGH;
          end else if (cnt_q == LAST_CNT) begin
            state_q <= LOW;
          end else begin
            cnt_q <= cnt_q + DBC_W'(1);
          end
        end
        default: state_q <= LOW;
      endcase
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/queue_occupancy_counter.sv
// Queue occupancy counter: conditions the rear (entry) and front (exit)
// photocells, keeps the saturating people count with full/empty flags and
// registers a validated teller count for the wait-time lookup.
// Optional sticky overflow/underflow flags: define QOC_ERR_FLAGS_EN.
module queue_occupancy_counter
  import sbqm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DBC_W           = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sensor_rear,
  input  logic                sensor_front,
  input  logic [TCOUNT_W-1:0] teller_req,
`ifdef QOC_ERR_FLAGS_EN
  input  logic                err_clr,
  output logic                ovf,
  output logic                udf,
`endif
  output logic [PCOUNT_W-1:0] people_count,
  output logic [TCOUNT_W-1:0] teller_count,
  output logic                full,
  output logic                empty,
  output logic                count_upd
);

  logic                evt_in;
  logic                evt_out;
  logic [PCOUNT_W-1:0] pcount_q, pcount_d;
  logic [TCOUNT_W-1:0] tcount_q, tcount_d;
  logic                full_q;
  logic                empty_q;
  logic                upd_q;

  sensor_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DBC_W          (DBC_W)
  ) u_rear (
    .clk     (clk),
    .rst     (rst),
    .sensor_i(sensor_rear),
    .evt_o   (evt_in)
  );

  sensor_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DBC_W          (DBC_W)
  ) u_front (
    .clk     (clk),
    .rst     (rst),
    .sensor_i(sensor_front),
    .evt_o   (evt_out)
  );

  // Saturating count: simultaneous entry and exit cancel out.
  always_comb begin
    pcount_d = pcount_q;
    if (evt_in && !evt_out && (pcount_q != PCOUNT_MAX)) begin
      pcount_d = pcount_q + 1'b1;
    end else if (evt_out && !evt_in && (pcount_q != '0)) begin
      pcount_d = pcount_q - 1'b1;
    end
  end

  // In two bits every nonzero request is in 1..3; zero is illegal and holds.
  always_comb begin
    tcount_d = tcount_q;
    if (teller_req != '0) begin
      tcount_d = teller_req;
    end
  end

  // Count, teller and flags are registered together so they never disagree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcount_q <= '0;
      tcount_q <= TCOUNT_MIN;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      upd_q    <= 1'b0;
    end else begin
      pcount_q <= pcount_d;
      tcount_q <= tcount_d;
      full_q   <= (pcount_d == PCOUNT_MAX);
      empty_q  <= (pcount_d == '0);
      upd_q    <= (pcount_d != pcount_q) || (tcount_d != tcount_q);
    end
  end

  assign people_count = pcount_q;
  assign teller_count = tcount_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign count_upd    = upd_q;

`ifdef QOC_ERR_FLAGS_EN
  logic ovf_set;
  logic udf_set;
  logic ovf_q;
  logic udf_q;

  assign ovf_set = evt_in && !evt_out && (pcount_q == PCOUNT_MAX);
  assign udf_set = evt_out && !evt_in && (pcount_q == '0);

  // Sticky error flags; a new set beats a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ovf_set)      ovf_q <= 1'b1;
      else if (err_clr) ovf_q <= 1'b0;
      if (udf_set)      udf_q <= 1'b1;
      else if (err_clr) udf_q <= 1'b0;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

endmodule

// File: tb/tb_queue_occupancy_counter.sv
// Self-checking bench for queue_occupancy_counter (DEBOUNCE_CYCLES=4).
// A cycle-level behavioural model runs alongside the DUT and is compared on
// every falling edge; directed literal checks pin the model's timing.
module tb_queue_occupancy_counter;
  import sbqm_pkg::*;

  localparam int D = 4;

  logic       clk          = 1'b0;
  logic       rst          = 1'b0;
  logic       sensor_rear  = 1'b0;
  logic       sensor_front = 1'b0;
  logic [1:0] teller_req   = 2'd1;
  logic [2:0] people_count;
  logic [1:0] teller_count;
  logic       full;
  logic       empty;
  logic       count_upd;
`ifdef QOC_ERR_FLAGS_EN
  logic       err_clr = 1'b0;
  logic       ovf;
  logic       udf;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  queue_occupancy_counter #(
    .DEBOUNCE_CYCLES(D),
    .DBC_W          (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sensor_rear (sensor_rear),
    .sensor_front(sensor_front),
    .teller_req  (teller_req),
`ifdef QOC_ERR_FLAGS_EN
    .err_clr     (err_clr),
    .ovf         (ovf),
    .udf         (udf),
`endif
    .people_count(people_count),
    .teller_count(teller_count),
    .full        (full),
    .empty       (empty),
    .count_upd   (count_upd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each sensor: raw level seen two edges late; the accepted level flips once
  // D consecutive observations disagree with it; a rise emits one event that
  // the counter consumes one edge later.
  int m_pc;
  int m_tc;
  bit m_full, m_empty, m_upd;
  bit m_ovf, m_udf;
  bit dly[2][$];
  int run_len[2];
  bit run_val[2];
  bit acc[2];
  bit evt_prev[2];

  task automatic model_reset();
    m_pc = 0; m_tc = 1; m_full = 0; m_empty = 1; m_upd = 0;
    m_ovf = 0; m_udf = 0;
    for (int c = 0; c < 2; c++) begin
      dly[c].delete();
      dly[c].push_back(1'b0);
      dly[c].push_back(1'b0);
      run_len[c] = 0; run_val[c] = 0; acc[c] = 0; evt_prev[c] = 0;
    end
  endtask

  task automatic model_step();
    int nxt;
    int ntc;
    bit ein;
    bit eout;
    bit clr;
    bit obs;
    bit raw;
    ein  = evt_prev[0];
    eout = evt_prev[1];
    clr  = 1'b0;
`ifdef QOC_ERR_FLAGS_EN
    clr  = err_clr;
`endif
    nxt = m_pc;
    if (ein && !eout) begin
      if (m_pc < 7) nxt = m_pc + 1;
      else          m_ovf = 1;
    end else if (eout && !ein) begin
      if (m_pc > 0) nxt = m_pc - 1;
      else          m_udf = 1;
    end
    if (clr && !(ein && !eout && m_pc == 7)) m_ovf = 0;
    if (clr && !(eout && !ein && m_pc == 0)) m_udf = 0;
    ntc     = (teller_req != 0) ? int'(teller_req) : m_tc;
    m_upd   = (nxt != m_pc) || (ntc != m_tc);
    m_pc    = nxt;
    m_tc    = ntc;
    m_full  = (m_pc == 7);
    m_empty = (m_pc == 0);
    for (int c = 0; c < 2; c++) begin
      raw = (c == 0) ? sensor_rear : sensor_front;
      obs = dly[c].pop_front();
      dly[c].push_back(raw);
      if (obs == run_val[c] && run_len[c] > 0) begin
        if (run_len[c] < 1000) run_len[c]++;
      end else begin
        run_val[c] = obs;
        run_len[c] = 1;
      end
      evt_prev[c] = 1'b0;
      if (run_val[c] != acc[c] && run_len[c] >= D) begin
        acc[c]      = run_val[c];
        evt_prev[c] = run_val[c];
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // Compare DUT against model away from the active edge.
  always @(negedge clk) begin
    if (rst || checks > 0 || $time > 20) begin
      check("people_count", people_count, m_pc);
      check("teller_count", teller_count, m_tc);
      check("full", full, m_full);
      check("empty", empty, m_empty);
      check("count_upd", count_upd, m_upd);
`ifdef QOC_ERR_FLAGS_EN
      check("ovf", ovf, m_ovf);
      check("udf", udf, m_udf);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic beam(input bit rear, input bit front, input int n);
    @(negedge clk);
    sensor_rear  = rear;
    sensor_front = front;
    repeat (n) @(negedge clk);
    sensor_rear  = 1'b0;
    sensor_front = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    // 1. reset state
    check("rst_pc", people_count, 0);
    check("rst_tc", teller_count, 1);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_upd", count_upd, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 2. long beam: event after 6 edges, count on the 7th
    sensor_rear = 1'b1;
    repeat (6) @(negedge clk);
    check("t2_pc_before", people_count, 0);
    @(negedge clk);
    check("t2_pc_after", people_count, 1);
    check("t2_upd", count_upd, 1);
    @(negedge clk);
    check("t2_upd_end", count_upd, 0);
    repeat (2) @(negedge clk);
    sensor_rear = 1'b0;
    repeat (14) @(negedge clk);
    check("t2_single", people_count, 1);

    // 3. short beam rejected; glitch inside long beam counts once
    beam(1, 0, 3);
    check("t3_short", people_count, 1);
    @(negedge clk);
    sensor_rear = 1'b1;
    repeat (10) @(negedge clk);
    sensor_rear = 1'b0;
    @(negedge clk);
    sensor_rear = 1'b1;
    repeat (9) @(negedge clk);
    sensor_rear = 1'b0;
    repeat (14) @(negedge clk);
    check("t3_glitch", people_count, 2);

    // 4. fill to 7, overflow ignored, one exit
    for (int i = 0; i < 5; i++) beam(1, 0, 8);
    check("t4_full_pc", people_count, 7);
    check("t4_full", full, 1);
    beam(1, 0, 8);
    check("t4_sat", people_count, 7);
`ifdef QOC_ERR_FLAGS_EN
    check("t4_ovf", ovf, 1);
`endif
    beam(0, 1, 8);
    check("t4_exit_pc", people_count, 6);
    check("t4_exit_full", full, 0);

    // 5. simultaneous events cancel; exit at empty ignored
    for (int i = 0; i < 3; i++) beam(0, 1, 8);
    check("t5_pc3", people_count, 3);
    beam(1, 1, 8);
    check("t5_both", people_count, 3);
    for (int i = 0; i < 3; i++) beam(0, 1, 8);
    beam(0, 1, 8);
    check("t5_udf_pc", people_count, 0);
    check("t5_empty", empty, 1);
`ifdef QOC_ERR_FLAGS_EN
    check("t5_udf", udf, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    check("t5_clr_udf", udf, 0);
    check("t5_clr_ovf", ovf, 0);
`endif

    // 6. teller register
    teller_req = 2'd2;
    @(negedge clk);
    check("t6_tc2", teller_count, 2);
    teller_req = 2'd0;
    repeat (2) @(negedge clk);
    check("t6_hold", teller_count, 2);
    teller_req = 2'd3;
    @(negedge clk);
    check("t6_tc3", teller_count, 3);

    // 6b. reset during RISE_CHK discards the pending event
    beam(1, 0, 8);
    check("t6_pre_rst", people_count, 1);
    teller_req  = 2'd0;
    sensor_rear = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    sensor_rear = 1'b0;
    check("t6_rst_pc", people_count, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (16) @(negedge clk);
    check("t6_no_evt", people_count, 0);
    check("t6_tc_rst", teller_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
